// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_parser
//  Purpose  : Sequences bytes from a UART receiver into command frames
//             (0x55 0xAA CMD LEN payload[LEN] CHECKSUM). Payload bytes are
//             written speculatively to an external buffer. Good frames and
//             errors are reported to the downstream command handler.
//  Ports    : sys_clk, sys_rst_n (async, active-low)
//             uart_done / uart_data   - receiver byte-complete level + byte
//             parser_clr              - synchronous abort to IDLE
//             wr_en/wr_addr/wr_data   - payload write port (1-cycle strobe)
//             frame_valid/frame_cmd/frame_len - good-frame pulse + last frame
//             err_csum/err_len/err_timeout    - error pulses
//             busy                    - high while the parser is mid-frame
//  Options  : `define UART_FRAME_TIMEOUT_EN builds the inter-byte timeout.
//             Without it err_timeout is 0 and a partial frame waits forever.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
    parameter int CLK_FREQ      = 50000000,
    parameter int UART_BPS      = 115200,
    parameter int MAX_LEN       = 16,
    parameter int ADDR_W        = 4,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_done,
    input  logic [7:0]        uart_data,
    input  logic              parser_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_valid,
    output logic [7:0]        frame_cmd,
    output logic [7:0]        frame_len,
    output logic              err_csum,
    output logic              err_len,
    output logic              err_timeout,
    output logic              busy
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_HEAD2 = 3'd1;
    localparam logic [2:0] c_CMD   = 3'd2;
    localparam logic [2:0] c_LEN   = 3'd3;
    localparam logic [2:0] c_DATA  = 3'd4;
    localparam logic [2:0] c_CSUM  = 3'd5;

    localparam int          c_BYTE_CLKS  = 10 * (CLK_FREQ / UART_BPS);
    localparam logic [23:0] c_TIMEOUT_TC = 24'(TIMEOUT_BYTES * c_BYTE_CLKS - 1);
    localparam logic [8:0]  c_MAX_LEN    = 9'(MAX_LEN);

    logic              r_uart_done_d;
    logic              w_byte_vld;
    logic              w_accept;
    logic              w_timeout;
    logic              w_len_bad;
    logic              w_last;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    logic [7:0]        r_cmd;
    logic [7:0]        r_len;
    logic [7:0]        r_sum;
    logic [ADDR_W-1:0] r_index;

    logic              w_wr_en;
    logic              w_frame_ok;
    logic              w_err_csum;
    logic              w_err_len;

    // uart_done is a level held for the whole byte; only its rising edge
    // marks a new byte.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_uart_done_d <= 1'b0;
        end else begin
            r_uart_done_d <= uart_done;
        end
    end

    assign w_byte_vld = uart_done & ~r_uart_done_d;
    // A clear in the same cycle discards the byte entirely.
    assign w_accept   = w_byte_vld & ~parser_clr;
    assign w_len_bad  = {1'b0, uart_data} > c_MAX_LEN;
    assign w_last     = (32'(r_index) == (32'(r_len) - 32'd1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (parser_clr || w_timeout) begin
            w_state_nxt = c_IDLE;
        end else if (w_byte_vld) begin
            case (r_state)
                c_IDLE:  w_state_nxt = (uart_data == 8'h55) ? c_HEAD2 : c_IDLE;
                c_HEAD2: begin
                    if (uart_data == 8'hAA) begin
                        w_state_nxt = c_CMD;
                    end else if (uart_data == 8'h55) begin
                        w_state_nxt = c_HEAD2;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
                c_CMD:   w_state_nxt = c_LEN;
                c_LEN: begin
                    if (w_len_bad) begin
                        w_state_nxt = c_IDLE;
                    end else if (uart_data == 8'h00) begin
                        w_state_nxt = c_CSUM;
                    end else begin
                        w_state_nxt = c_DATA;
                    end
                end
                c_DATA:  w_state_nxt = w_last ? c_CSUM : c_DATA;
                c_CSUM:  w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        w_wr_en    = 1'b0;
        w_frame_ok = 1'b0;
        w_err_csum = 1'b0;
        w_err_len  = 1'b0;
        if (w_accept) begin
            case (r_state)
                c_LEN:   w_err_len = w_len_bad;
                c_DATA:  w_wr_en   = 1'b1;
                c_CSUM: begin
                    w_frame_ok = (uart_data == r_sum);
                    w_err_csum = (uart_data != r_sum);
                end
                default: ;
            endcase
        end
    end

    // ---------------- Frame datapath ----------------
    // Checksum covers CMD, LEN and payload only; header bytes are excluded.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cmd   <= 8'h00;
            r_len   <= 8'h00;
            r_sum   <= 8'h00;
            r_index <= '0;
        end else if (parser_clr) begin
            r_sum   <= 8'h00;
            r_index <= '0;
        end else if (w_accept) begin
            case (r_state)
                c_CMD: begin
                    r_cmd <= uart_data;
                    r_sum <= uart_data;
                end
                c_LEN: begin
                    if (!w_len_bad) begin
                        r_len   <= uart_data;
                        r_sum   <= r_sum + uart_data;
                        r_index <= '0;
                    end
                end
                c_DATA: begin
                    r_sum   <= r_sum + uart_data;
                    r_index <= r_index + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // ---------------- Registered outputs ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 8'h00;
            frame_valid <= 1'b0;
            frame_cmd   <= 8'h00;
            frame_len   <= 8'h00;
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            wr_en       <= w_wr_en;
            frame_valid <= w_frame_ok;
            err_csum    <= w_err_csum;
            err_len     <= w_err_len;
            // Decoding the next state keeps busy aligned with the state register.
            busy        <= (w_state_nxt != c_IDLE);
            if (w_wr_en) begin
                wr_addr <= r_index;
                wr_data <= uart_data;
            end
            if (w_frame_ok) begin
                frame_cmd <= r_cmd;
                frame_len <= r_len;
            end
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    // ---------------- Inter-byte timeout ----------------
    logic [23:0] r_to_cnt;
    logic        r_err_timeout;

    // A byte arriving on the terminal count wins; a clear beats both.
    assign w_timeout = (r_state != c_IDLE) && (r_to_cnt == c_TIMEOUT_TC)
                       && !w_byte_vld && !parser_clr;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_to_cnt      <= 24'd0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_timeout;
            if (parser_clr || w_byte_vld || w_timeout || (r_state == c_IDLE)) begin
                r_to_cnt <= 24'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 24'd1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign err_timeout  = 1'b0;
    // Timing parameters only matter when the timeout counter is built.
    assign w_unused_cfg = ^c_TIMEOUT_TC;
`endif

endmodule
`default_nettype wire
